ysyx_22040750_md_seq: RTL
=========================

# ysyx_22040750_md_seq

Iteration sequencer for the shared multi-cycle mul/div datapath inside the EX stage. It accepts a multi-cycle instruction from ID/EX, pulses start, counts the iteration cycles, and short-circuits divide-by-zero. It captures the datapath result into a holding register, holds it until EX/MEM accepts it, and stalls the pipeline for the whole interval. Single-cycle ALU ops pass by untouched; the sequencer only engages when `I_multicycle` is high.

## Interface
Parameters:
- `MUL_CYCLES`, 32: step cycles for a 64-bit multiply.
- `MUL_W_CYCLES`, 16: step cycles for a word (`*W`) multiply.
- `DIV_CYCLES`, 64: step cycles for a 64-bit div/rem.
- `DIV_W_CYCLES`, 32: step cycles for a word div/rem.
- `CNT_W`, 7: iteration counter width. Must satisfy 2^CNT_W > max cycle parameter.

Ports (clock `I_sys_clk`, single clock; reset `I_rst`, synchronous, active-low):
- `I_sys_clk` in 1: clock.
- `I_rst` in 1: synchronous active-low reset.
- `I_ID_EX_valid` in 1: EX holds a valid instruction.
- `I_multicycle` in 1: the instruction uses the mul/div datapath.
- `I_is_div` in 1: 1 = div/rem class, 0 = mul class.
- `I_word_op` in 1: 32-bit word variant.
- `I_op2_zero` in 1: divisor equals zero, after word masking.
- `I_flush` in 1: kill the in-flight instruction.
- `I_EX_MEM_ready` in 1: downstream accepts the result.
- `I_md_result` in 64: datapath result, valid in the last step cycle.
- `O_md_start` out 1: load operands into the datapath (one-cycle pulse).
- `O_md_step` out 1: datapath iterate enable.
- `O_md_dbz` out 1: datapath selects the divide-by-zero result (quotient all-ones, remainder = dividend).
- `O_stall` out 1: freeze IF/ID/ID-EX.
- `O_result` out 64: held result.
- `O_result_valid` out 1: `O_result` is valid.

## Operation
- States: IDLE, RUN, DONE.
- `accept` = IDLE & `I_ID_EX_valid` & `I_multicycle` & !`I_flush`.
- IDLE:
  - On `accept`: `O_md_start`=1 (combinational), latch is_div/word/dbz, go to RUN.
  - Counter load:
    - dbz & is_div → 0.
    - Otherwise → N−1, where N is selected from the four parameters by is_div/word.
- RUN:
  - `O_md_step`=1 and `O_md_dbz`=latched dbz.
  - cnt≠0 → decrement.
  - cnt==0 → capture `I_md_result` into `O_result`, set valid, go to DONE.
- DONE:
  - `O_result_valid`=1.
  - `I_EX_MEM_ready` → clear valid, go to IDLE.
  - No new accept happens in the same cycle, so there is a fixed one-cycle bubble.
- `O_stall` = `accept` | RUN | (DONE & !`I_EX_MEM_ready`).
- `I_flush`, any state:
  - Next state is IDLE and valid clears.
  - No capture occurs, `O_md_step` is forced 0 that cycle, and there is no accept.
  - Flush has priority over capture and accept.
- The `I_op2_zero` short-cut applies only when `I_is_div`=1. For mul it is ignored.
- `I_multicycle`=0 never changes state.
- Reset (`I_rst`=0 at a clock edge):
  - State IDLE, cnt 0, `O_result` 0, `O_result_valid` 0.
  - Latched flags cleared.
  - `O_md_start`/`O_md_step`/`O_md_dbz`/`O_stall` all 0.
  - Reset overrides every other input, including mid-RUN.

## Timing
- Cycle 0: accept, with `O_md_start` and `O_stall` high.
- Cycles 1..N: RUN with `O_md_step` high. Capture happens at the end of cycle N.
- Cycle N+1: `O_result_valid`=1 and `O_stall` = !`I_EX_MEM_ready`.
- Total latency from accept to valid is N+1 cycles. Divide-by-zero takes 2 cycles.
- `O_result`/`O_result_valid` are registered. `O_md_start`, `O_md_step`, and `O_stall` are combinational from state and inputs.
- The counter never wraps. It decrements only in RUN while cnt≠0.
- `O_result` holds its value after valid drops, until the next capture.

## Structure
- Shared package: the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the mul/div cycle-count defaults. The mul/div datapath interface widths are also shared with the ALU.
- The cycle-count selection (is_div/word → N−1) is a natural single sub-module, `ysyx_22040750_md_cnt_sel`. Everything else stays flat.

## Test plan
- 64-bit DIV, divisor≠0, `I_EX_MEM_ready`=1:
  - `O_md_start` pulses at cycle 0 and `O_md_step` is high for cycles 1–64.
  - `O_result_valid` is high at cycle 65 with `O_result`=`I_md_result` as sampled in cycle 64.
  - `O_stall` is high for cycles 0–64 and low at 65.
- MULW (word=1, div=0): valid at cycle 17. A DIVW with `I_op2_zero`=1 gives step at cycle 1 only, `O_md_dbz`=1, and valid at cycle 2.
- Backpressure: `I_EX_MEM_ready`=0 for 5 cycles after valid.
  - Valid and `O_result` stay stable and `O_stall` stays high.
  - On ready, valid drops next cycle, and a new multicycle op is accepted one cycle later, not the same cycle.
- Flush at RUN cycle 10 of a DIV:
  - Next cycle is IDLE, with no valid and `O_result` unchanged.
  - A flush coinciding with the cnt==0 capture cycle produces no capture either.
- Reset (`I_rst`=0) mid-RUN: all outputs 0 the next cycle. A non-multicycle instruction with `I_ID_EX_valid`=1 never asserts `O_stall`.

Source files
------------

// File: rtl/ysyx_22040750_md_seq_pkg.sv
// Shared definitions for the EX-stage mul/div sequencer: state encoding,
// default iteration counts and the datapath width shared with the ALU.
package ysyx_22040750_md_seq_pkg;

  localparam int MD_DATA_W       = 64;
  localparam int MD_CNT_W        = 7;
  localparam int MD_MUL_CYCLES   = 32;
  localparam int MD_MUL_W_CYCLES = 16;
  localparam int MD_DIV_CYCLES   = 64;
  localparam int MD_DIV_W_CYCLES = 32;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/ysyx_22040750_md_seq_cnt_sel.sv
// Selects the iteration counter preload (step cycles minus one) for the
// operation class and width being issued.
module ysyx_22040750_md_cnt_sel
  import ysyx_22040750_md_seq_pkg::*;
#(
  parameter int MUL_CYCLES   = MD_MUL_CYCLES,
  parameter int MUL_W_CYCLES = MD_MUL_W_CYCLES,
  parameter int DIV_CYCLES   = MD_DIV_CYCLES,
  parameter int DIV_W_CYCLES = MD_DIV_W_CYCLES,
  parameter int CNT_W        = MD_CNT_W
) (
  input  logic             I_is_div,
  input  logic             I_word_op,
  output logic [CNT_W-1:0] O_cnt_init
);

  localparam logic [CNT_W-1:0] MUL_INIT   = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] MUL_W_INIT = CNT_W'(MUL_W_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_INIT   = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_W_INIT = CNT_W'(DIV_W_CYCLES - 1);

  always_comb begin
    O_cnt_init = MUL_INIT;
    case ({I_is_div, I_word_op})
      2'b00:   O_cnt_init = MUL_INIT;
      2'b01:   O_cnt_init = MUL_W_INIT;
      2'b10:   O_cnt_init = DIV_INIT;
      default: O_cnt_init = DIV_W_INIT;
    endcase
  end

endmodule

// File: rtl/ysyx_22040750_md_seq.sv
// Iteration sequencer for the shared multi-cycle mul/div datapath: issues
// start/step, holds the result until EX/MEM takes it, and stalls meanwhile.
module ysyx_22040750_md_seq
  import ysyx_22040750_md_seq_pkg::*;
#(
  parameter int MUL_CYCLES   = MD_MUL_CYCLES,
  parameter int MUL_W_CYCLES = MD_MUL_W_CYCLES,
  parameter int DIV_CYCLES   = MD_DIV_CYCLES,
  parameter int DIV_W_CYCLES = MD_DIV_W_CYCLES,
  parameter int CNT_W        = MD_CNT_W
) (
  input  logic                 I_sys_clk,
  input  logic                 I_rst,
  input  logic                 I_ID_EX_valid,
  input  logic                 I_multicycle,
  input  logic                 I_is_div,
  input  logic                 I_word_op,
  input  logic                 I_op2_zero,
  input  logic                 I_flush,
  input  logic                 I_EX_MEM_ready,
  input  logic [MD_DATA_W-1:0] I_md_result,
  output logic                 O_md_start,
  output logic                 O_md_step,
  output logic                 O_md_dbz,
  output logic                 O_stall,
  output logic [MD_DATA_W-1:0] O_result,
  output logic                 O_result_valid
);

  md_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   is_div_q, is_div_d;
  logic                   dbz_q, dbz_d;
  logic [MD_DATA_W-1:0]   result_q, result_d;
  logic                   valid_q, valid_d;
  logic [CNT_W-1:0]       cnt_init;
  logic                   accept;

  ysyx_22040750_md_cnt_sel #(
    .MUL_CYCLES  (MUL_CYCLES),
    .MUL_W_CYCLES(MUL_W_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .DIV_W_CYCLES(DIV_W_CYCLES),
    .CNT_W       (CNT_W)
  ) u_cnt_sel (
    .I_is_div  (I_is_div),
    .I_word_op (I_word_op),
    .O_cnt_init(cnt_init)
  );

  assign accept = (state_q == MD_IDLE) && I_ID_EX_valid && I_multicycle && !I_flush;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    dbz_d      = dbz_q;
    result_d   = result_q;
    valid_d    = valid_q;
    O_md_start = 1'b0;
    O_md_step  = 1'b0;
    O_md_dbz   = 1'b0;
    O_stall    = 1'b0;

    case (state_q)
      MD_IDLE: begin
        if (accept) begin
          O_md_start = 1'b1;
          O_stall    = 1'b1;
          is_div_d   = I_is_div;
          dbz_d      = I_is_div & I_op2_zero;
          // Divide-by-zero needs a single step to select the fixed result.
          cnt_d      = (I_is_div && I_op2_zero) ? '0 : cnt_init;
          state_d    = MD_RUN;
        end
      end
      MD_RUN: begin
        O_stall   = 1'b1;
        O_md_step = !I_flush;
        O_md_dbz  = dbz_q & is_div_q;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          result_d = I_md_result;
          valid_d  = 1'b1;
          state_d  = MD_DONE;
        end
      end
      MD_DONE: begin
        O_stall = !I_EX_MEM_ready;
        if (I_EX_MEM_ready) begin
          valid_d = 1'b0;
          state_d = MD_IDLE;
        end
      end
      default: state_d = MD_IDLE;
    endcase

    // Flush kills the op outright, including a capture due this cycle.
    if (I_flush) begin
      state_d  = MD_IDLE;
      valid_d  = 1'b0;
      result_d = result_q;
    end

    if (!I_rst) begin
      O_md_start = 1'b0;
      O_md_step  = 1'b0;
      O_md_dbz   = 1'b0;
      O_stall    = 1'b0;
    end
  end

  always_ff @(posedge I_sys_clk) begin
    if (!I_rst) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      dbz_q    <= 1'b0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      dbz_q    <= dbz_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign O_result       = result_q;
  assign O_result_valid = valid_q;

endmodule
